// File: rtl/prng_sampler.sv
// prng_sampler: CHANNELS independent xorshift64 generators feeding a
// valid/ready output stream, with a wrapping count of accepted vectors.
//
// Optional feature, macro PRNG_SAMPLER_RANGE_MAP_EN:
//   when defined, a second registered stage scales each raw sample into
//   [0, range[c]) as (sample * range) >> OUT_W. This adds one cycle of
//   latency. When the macro is undefined, out_data is the raw stage-1
//   sample and the range input is ignored.
//
// The whole pipeline advances together whenever the output register is
// empty or being drained, so there are no partial stalls. Reseed takes
// priority over advance and restarts every generator from its derived seed.

module prng_sampler #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 16,
  parameter int COUNT_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [63:0]               seed,
  input  logic                      reseed,
  input  logic [CHANNELS*OUT_W-1:0] range,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic [COUNT_W-1:0]        sample_count
);

  // Golden-ratio constant spreads the per-channel seeds apart.
  localparam logic [63:0] GOLDEN = 64'h9E3779B97F4A7C15;

  function automatic logic [63:0] derive_seed(input logic [63:0] base, input int c);
    logic [63:0] cv;
    logic [63:0] d;
    cv = 64'(c);
    d  = base ^ (cv * GOLDEN);
    // xorshift has a fixed point at zero, so a zero seed would never move.
    if (d == 64'h0) d = 64'h1;
    return d;
  endfunction

  function automatic logic [63:0] xs_step(input logic [63:0] x);
    logic [63:0] x1;
    logic [63:0] x2;
    x1 = x ^ (x << 13);
    x2 = x1 ^ (x1 >> 7);
    return x2 ^ (x2 << 17);
  endfunction

  logic [63:0]                   s_q      [CHANNELS];
  logic [63:0]                   s_d      [CHANNELS];
  logic [63:0]                   seed_der [CHANNELS];
  logic [63:0]                   stepped  [CHANNELS];
  logic [CHANNELS-1:0][OUT_W-1:0] samp_q;
  logic [CHANNELS-1:0][OUT_W-1:0] samp_d;
  logic                          v1_q;
  logic                          v1_d;
  logic [COUNT_W-1:0]            cnt_q;
  logic [COUNT_W-1:0]            cnt_d;
  logic                          advance;
  logic                          xfer;

  assign advance      = !out_valid || out_ready;
  assign xfer         = out_valid && out_ready;
  assign sample_count = cnt_q;

  // Derived seeds and the next generator value for every channel.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      seed_der[c] = derive_seed(seed, c);
      stepped[c]  = xs_step(s_q[c]);
    end
  end

  // Generator states, stage-1 samples, stage-1 valid and the transfer count.
  always_comb begin
    s_d    = s_q;
    samp_d = samp_q;
    v1_d   = v1_q;
    cnt_d  = cnt_q;
    if (reseed) begin
      s_d    = seed_der;
      samp_d = '0;
      v1_d   = 1'b0;
      cnt_d  = '0;
    end else begin
      if (advance) begin
        for (int c = 0; c < CHANNELS; c++) begin
          s_d[c]    = stepped[c];
          samp_d[c] = stepped[c][63 -: OUT_W];
        end
        v1_d = 1'b1;
      end
      if (xfer) cnt_d = cnt_q + COUNT_W'(1);
    end
  end

  // Stage-1 registers; reset loads the derived seeds directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= seed_der;
      samp_q <= '0;
      v1_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s_q    <= s_d;
      samp_q <= samp_d;
      v1_q   <= v1_d;
      cnt_q  <= cnt_d;
    end
  end

`ifdef PRNG_SAMPLER_RANGE_MAP_EN

  logic [CHANNELS-1:0][OUT_W-1:0] map_q;
  logic [CHANNELS-1:0][OUT_W-1:0] map_d;
  logic [2*OUT_W-1:0]             prod [CHANNELS];
  logic                           v2_q;
  logic                           v2_d;

  // Full-width product keeps the upper half exact, so the result is below range.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      prod[c] = {{OUT_W{1'b0}}, samp_q[c]} * {{OUT_W{1'b0}}, range[c*OUT_W +: OUT_W]};
    end
  end

  // Stage-2 next state: scaled samples follow stage 1 on every advance.
  always_comb begin
    map_d = map_q;
    v2_d  = v2_q;
    if (reseed) begin
      map_d = '0;
      v2_d  = 1'b0;
    end else if (advance) begin
      for (int c = 0; c < CHANNELS; c++) begin
        map_d[c] = prod[c][2*OUT_W-1 -: OUT_W];
      end
      v2_d = v1_q;
    end
  end

  // Stage-2 registers drive the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      map_q <= map_d;
      v2_q  <= v2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_data  = map_q;

`else

  logic unused_range;
  assign unused_range = ^range;

  assign out_valid = v1_q;
  assign out_data  = samp_q;

`endif

endmodule
